pipe_scorer: RTL and testbench

- Upstream stage of the seven-segment score digit counter.
- Scrolls a single pipe across the LED-matrix columns and latches the pipe's gap position.
- Compares the bird row against the gap while the pipe occupies the bird column.
- Produces a one-cycle score pulse when the bird clears the pipe, and a latched crush level on collision. Both feed the score counter's score and crush inputs.

---
 rtl/pipe_scorer_if.sv | 26 ++
 rtl/pipe_scorer.sv | 133 +++++++++++++
 tb/tb_pipe_scorer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scorer_if.sv
// pipe_scorer_if: bundles the game-control inputs and pipe/score outputs.
// master drives start/tick/fail/bird_row/gap_in; slave returns pipe state.
interface pipe_scorer_if #(
  parameter int CW = 4
);
  logic          start;
  logic          tick;
  logic          fail;
  logic [CW-1:0] bird_row;
  logic [CW-1:0] gap_in;
  logic [CW-1:0] pipe_col;
  logic [CW-1:0] gap_top;
  logic          pipe_active;
  logic          score;
  logic          crush;

  modport master (
    output start, tick, fail, bird_row, gap_in,
    input  pipe_col, gap_top, pipe_active, score, crush
  );

  modport slave (
    input  start, tick, fail, bird_row, gap_in,
    output pipe_col, gap_top, pipe_active, score, crush
  );
endinterface

// File: rtl/pipe_scorer.sv
// pipe_scorer: scrolls one pipe across the matrix, scores clean passes,
// latches crush on collision. Ports: Clock, reset (sync, active-high), io.
module pipe_scorer #(
  parameter int COLS      = 16,
  parameter int ROWS      = 16,
  parameter int BIRD_COL  = 3,
  parameter int GAP_H     = 4,
  parameter int SPAWN_GAP = 2,
  parameter int CW        = 4
) (
  input logic          Clock,
  input logic          reset,
  pipe_scorer_if.slave io
);

  localparam int W1 = CW + 1;
  localparam logic [CW-1:0] LAST  = CW'(COLS - 1);
  localparam logic [CW-1:0] GMAX  = CW'(ROWS - GAP_H);
  localparam logic [CW-1:0] BIRD  = CW'(BIRD_COL);
  localparam logic [CW-1:0] SPAWN = CW'(SPAWN_GAP);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SCROLL,
    OVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  logic          score_q, score_d;
  logic          crush_q, crush_d;

  logic [W1-1:0] gap_bot;
  logic          in_gap;
  logic          at_bird;
  logic [CW-1:0] gap_clamp;

  // Bottom row computed one bit wider so gap_top+GAP_H-1 cannot wrap.
  assign gap_bot   = {1'b0, gap_q} + W1'(GAP_H - 1);
  assign in_gap    = (io.bird_row >= gap_q) &&
                     ({1'b0, io.bird_row} <= gap_bot);
  assign at_bird   = (col_q == BIRD);
  assign gap_clamp = (io.gap_in > GMAX) ? GMAX : io.gap_in;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    score_d = 1'b0;
    crush_d = crush_q;
    if (io.start) begin
      unique case (state_q)
        IDLE: begin
          if (io.fail) begin
            state_d = OVER;
          end else begin
            state_d = WAIT;
            cnt_d   = SPAWN;
          end
        end
        WAIT: begin
          if (io.fail) begin
            state_d = OVER;
          end else if (io.tick) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
              state_d = SCROLL;
              col_d   = LAST;
              act_d   = 1'b1;
              gap_d   = gap_clamp;
            end
          end
        end
        SCROLL: begin
          if (io.fail) begin
            state_d = OVER;
          end else if (act_q && at_bird && !in_gap) begin
            // Collision is checked every cycle, not only on ticks.
            state_d = OVER;
            crush_d = 1'b1;
          end else if (io.tick) begin
            score_d = at_bird && in_gap;
            if (col_q == '0) begin
              state_d = WAIT;
              act_d   = 1'b0;
              cnt_d   = SPAWN;
            end else begin
              col_d = col_q - 1'b1;
            end
          end
        end
        OVER: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= LAST;
      gap_q   <= '0;
      cnt_q   <= SPAWN;
      act_q   <= 1'b0;
      score_q <= 1'b0;
      crush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      score_q <= score_d;
      crush_q <= crush_d;
    end
  end

  assign io.pipe_col    = col_q;
  assign io.gap_top     = gap_q;
  assign io.pipe_active = act_q;
  assign io.score       = score_q;
  assign io.crush       = crush_q;

endmodule

// File: tb/tb_pipe_scorer.sv
// tb_pipe_scorer: directed + random stimulus, reference model feeds a
// scoreboard queue that a negedge monitor checks against the DUT.
module tb_pipe_scorer;

  localparam int COLS  = 16;
  localparam int ROWS  = 16;
  localparam int BIRD  = 3;
  localparam int GAP_H = 4;
  localparam int SPAWN = 2;

  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_SCROLL = 2;
  localparam int M_OVER   = 3;

  typedef struct {
    int col;
    int gap;
    bit act;
    bit score;
    bit crush;
  } exp_t;

  logic Clock;
  logic reset;
  pipe_scorer_if #(.CW(4)) io ();

  pipe_scorer dut (
    .Clock(Clock),
    .reset(reset),
    .io   (io)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];

  // Reference model: game described as a mode plus pipe position.
  int mode = M_IDLE;
  int m_col = COLS - 1;
  int m_gap = 0;
  int m_wait = SPAWN;
  bit m_on = 0;
  bit m_score = 0;
  bit m_crush = 0;

  int br_v = 0;
  int gi_v = 0;

  task automatic model(bit r, bit s, bit t, bit f, int br, int gi);
    bit ingap;
    m_score = 0;
    if (r) begin
      mode = M_IDLE; m_col = COLS - 1; m_gap = 0;
      m_on = 0; m_crush = 0; m_wait = SPAWN;
      return;
    end
    if (!s || mode == M_OVER) return;
    if (f) begin
      mode = M_OVER;
      return;
    end
    ingap = (br >= m_gap) && (br < m_gap + GAP_H);
    case (mode)
      M_IDLE: begin
        mode = M_WAIT;
        m_wait = SPAWN;
      end
      M_WAIT: if (t) begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          mode = M_SCROLL;
          m_col = COLS - 1;
          m_on = 1;
          m_gap = (gi > ROWS - GAP_H) ? ROWS - GAP_H : gi;
        end
      end
      M_SCROLL: begin
        if (m_on && m_col == BIRD && !ingap) begin
          m_crush = 1;
          mode = M_OVER;
        end else if (t) begin
          if (m_col == BIRD && ingap) m_score = 1;
          if (m_col == 0) begin
            m_on = 0;
            m_wait = SPAWN;
            mode = M_WAIT;
          end else begin
            m_col = m_col - 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic cyc(bit r, bit s, bit t, bit f, int br, int gi);
    exp_t e;
    reset = r;
    io.start = s;
    io.tick = t;
    io.fail = f;
    io.bird_row = 4'(br);
    io.gap_in = 4'(gi);
    model(r, s, t, f, br, gi);
    e = '{m_col, m_gap, m_on, m_score, m_crush};
    @(posedge Clock);
    q.push_back(e);
    #1;
  endtask

  task automatic chk(string name, logic [3:0] act, int exp);
    n_total++;
    if (act !== 4'(exp))
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, br_v, gi_v);
    cyc(1, 0, 0, 0, br_v, gi_v);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 1, 0, br_v, gi_v);
      cyc(0, 1, 0, 0, br_v, gi_v);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_total++;
      if (io.pipe_col !== 4'(e.col) || io.gap_top !== 4'(e.gap) ||
          io.pipe_active !== e.act || io.score !== e.score ||
          io.crush !== e.crush)
        $display("FAIL cycle t=%0t: col/gap/act/score/crush got %0d/%0d/%0b/%0b/%0b expected %0d/%0d/%0b/%0b/%0b",
                 $time, io.pipe_col, io.gap_top, io.pipe_active, io.score,
                 io.crush, e.col, e.gap, e.act, e.score, e.crush);
      else
        n_pass++;
    end
  end

  initial begin
    bit r, s, t, f;
    int wait_cnt;

    // Reset values
    do_reset();
    chk("rst_col", io.pipe_col, 15);
    chk("rst_act", 4'(io.pipe_active), 0);
    chk("rst_score", 4'(io.score), 0);
    chk("rst_crush", 4'(io.crush), 0);
    chk("rst_gap", io.gap_top, 0);

    // Clean pass
    br_v = 6; gi_v = 5;
    cyc(0, 1, 0, 0, br_v, gi_v);
    ticks(2);
    chk("spawn_act", 4'(io.pipe_active), 1);
    chk("spawn_col", io.pipe_col, 15);
    chk("spawn_gap", io.gap_top, 5);
    ticks(12);
    chk("pass_col3", io.pipe_col, 3);
    cyc(0, 1, 1, 0, br_v, gi_v);
    chk("pass_col2", io.pipe_col, 2);
    chk("pass_score1", 4'(io.score), 1);
    cyc(0, 1, 0, 0, br_v, gi_v);
    chk("pass_score0", 4'(io.score), 0);

    // Collision
    do_reset();
    br_v = 10; gi_v = 5;
    cyc(0, 1, 0, 0, br_v, gi_v);
    ticks(14);
    chk("col_crush", 4'(io.crush), 1);
    ticks(3);
    chk("col_hold", io.pipe_col, 3);
    chk("col_crush_hold", 4'(io.crush), 1);
    chk("col_noscore", 4'(io.score), 0);

    // Clamp and respawn
    do_reset();
    br_v = 13; gi_v = 15;
    cyc(0, 1, 0, 0, br_v, gi_v);
    ticks(2);
    chk("clamp_gap", io.gap_top, 12);
    gi_v = 7;
    ticks(15);
    chk("at_col0", io.pipe_col, 0);
    ticks(1);
    chk("leave_act", 4'(io.pipe_active), 0);
    chk("leave_col", io.pipe_col, 0);
    ticks(1);
    chk("respawn_wait", 4'(io.pipe_active), 0);
    ticks(1);
    chk("respawn_act", 4'(io.pipe_active), 1);
    chk("respawn_col", io.pipe_col, 15);
    chk("respawn_gap", io.gap_top, 7);

    // Fail priority
    do_reset();
    br_v = 6; gi_v = 5;
    cyc(0, 1, 0, 0, br_v, gi_v);
    ticks(14);
    cyc(0, 1, 1, 1, br_v, gi_v);
    chk("fail_score", 4'(io.score), 0);
    chk("fail_crush", 4'(io.crush), 0);
    chk("fail_col", io.pipe_col, 3);
    ticks(3);
    chk("fail_frozen", io.pipe_col, 3);

    // Freeze
    do_reset();
    cyc(0, 1, 0, 0, br_v, gi_v);
    ticks(8);
    chk("frz_col9", io.pipe_col, 9);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, br_v, gi_v);
      cyc(0, 0, 0, 0, br_v, gi_v);
    end
    chk("frz_hold", io.pipe_col, 9);
    cyc(0, 1, 1, 0, br_v, gi_v);
    chk("frz_resume", io.pipe_col, 8);

    // Random
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) == 0) ||
          (mode == M_OVER && $urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 19) != 0);
      t = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 29) == 0) br_v = $urandom_range(0, 15);
      gi_v = $urandom_range(0, 15);
      cyc(r, s, t, f, br_v, gi_v);
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 5) begin
      @(negedge Clock);
      #1;
      wait_cnt++;
    end
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
